// File: rtl/dh_shared_key_calc_if.sv
// rtl/dh_shared_key_calc_if.sv - start/done request and result bundle for the DH shared key engine
interface dh_shared_key_calc_if #(
  parameter int WIDTH = 32,
  parameter int EXP_W = 32
);
  logic             start;
  logic [WIDTH-1:0] base_in;
  logic [EXP_W-1:0] exp_in;
  logic [WIDTH-1:0] p;
  logic             busy;
  logic             done;
  logic             key_valid;
  logic [WIDTH-1:0] key;
  logic             err;

  modport master (
    output start, base_in, exp_in, p,
    input  busy, done, key_valid, key, err
  );

  modport slave (
    input  start, base_in, exp_in, p,
    output busy, done, key_valid, key, err
  );
endinterface

// File: rtl/dh_shared_key_calc.sv
// rtl/dh_shared_key_calc.sv - DH shared key engine, key = base^exp mod p, right-to-left square-and-multiply
// Optional DH_EARLY_EXIT_EN: leave RUN once the remaining exponent bits are all zero.
module dh_shared_key_calc #(
  parameter int WIDTH = 32,
  parameter int EXP_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  dh_shared_key_calc_if.slave bus
);
  localparam int BW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0] b_r, acc_r, p_r, key_r;
  logic [EXP_W-1:0] exp_r;
  logic [BW-1:0]    bit_idx;
  logic             key_valid_r, err_r;

  logic [2*WIDTH-1:0] p_ext, mul_acc, mul_sq;
  logic [WIDTH-1:0]   acc_next, sq_next;
  logic               p_bad, last_bit;

  // Full double-width products reduced in the same cycle; nothing is truncated before the mod.
  always_comb begin
    p_ext    = {{WIDTH{1'b0}}, p_r};
    mul_acc  = {{WIDTH{1'b0}}, acc_r} * {{WIDTH{1'b0}}, b_r};
    mul_sq   = {{WIDTH{1'b0}}, b_r} * {{WIDTH{1'b0}}, b_r};
    acc_next = exp_r[bit_idx] ? WIDTH'(mul_acc % p_ext) : acc_r;
    sq_next  = WIDTH'(mul_sq % p_ext);
    p_bad    = p_r < WIDTH'(2);
`ifdef DH_EARLY_EXIT_EN
    last_bit = (bit_idx == BW'(EXP_W - 1)) || (((exp_r >> bit_idx) >> 1) == '0);
`else
    last_bit = (bit_idx == BW'(EXP_W - 1));
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: if (bus.start) state_next = LOAD;
      LOAD: begin
        bus.busy   = 1'b1;
        state_next = p_bad ? FIN : RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last_bit) state_next = FIN;
      end
      FIN: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The result registers are written on the edge entering FIN so they are valid alongside done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_r         <= '0;
      acc_r       <= '0;
      p_r         <= '0;
      exp_r       <= '0;
      bit_idx     <= '0;
      key_r       <= '0;
      key_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          b_r         <= bus.base_in;
          exp_r       <= bus.exp_in;
          p_r         <= bus.p;
          key_r       <= '0;
          key_valid_r <= 1'b0;
          err_r       <= 1'b0;
        end
        LOAD: if (p_bad) begin
          err_r <= 1'b1;
          key_r <= '0;
        end else begin
          b_r     <= b_r % p_r;
          acc_r   <= WIDTH'(1);
          bit_idx <= '0;
        end
        RUN: begin
          acc_r   <= acc_next;
          b_r     <= sq_next;
          bit_idx <= bit_idx + BW'(1);
          if (last_bit) begin
            key_r       <= acc_next;
            key_valid_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.key       = key_r;
  assign bus.key_valid = key_valid_r;
  assign bus.err       = err_r;
endmodule
